// File: rtl/pll_cfg_initiator_if.sv
// Bundles the command, response, PLL-wrapper and lock-monitor signals of pll_cfg_initiator.
// master: the initiator's view (drives cfg_*_o, rsp_*_o, cmd_ready_o, lock_*_o).
// slave: the SoC control path plus PLL wrapper view (drives cmd_*_i, rsp_ready_i, cfg_*_i).
interface pll_cfg_initiator_if #(
  parameter int LOSS_CNT_W = 8
);
  // SoC command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [1:0]            cmd_add_i;
  logic [31:0]           cmd_data_i;
  logic                  cmd_wrn_i;
  // SoC response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_data_o;
  logic                  rsp_err_o;
  // PLL wrapper configuration port
  logic                  cfg_req_o;
  logic                  cfg_ack_i;
  logic [1:0]            cfg_add_o;
  logic [31:0]           cfg_data_o;
  logic                  cfg_wrn_o;
  logic [31:0]           cfg_r_data_i;
  // PLL lock monitor
  logic                  cfg_lock_i;
  logic                  lock_o;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt_o;
  logic                  lock_loss_irq_o;

  modport master (
    input  cmd_valid_i, cmd_add_i, cmd_data_i, cmd_wrn_i, rsp_ready_i,
           cfg_ack_i, cfg_r_data_i, cfg_lock_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           cfg_req_o, cfg_add_o, cfg_data_o, cfg_wrn_o,
           lock_o, lock_loss_cnt_o, lock_loss_irq_o
  );

  modport slave (
    output cmd_valid_i, cmd_add_i, cmd_data_i, cmd_wrn_i, rsp_ready_i,
           cfg_ack_i, cfg_r_data_i, cfg_lock_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           cfg_req_o, cfg_add_o, cfg_data_o, cfg_wrn_o,
           lock_o, lock_loss_cnt_o, lock_loss_irq_o
  );
endinterface

// File: rtl/pll_cfg_initiator.sv
// Purpose: PLL config-port initiator (single read/write per command) plus lock sync and loss counter.
// Latency: command-to-response >= 2 cycles; lock input to lock_o 2 edges, loss irq/count 1 edge later.
// Backpressure: cmd_ready_o low from acceptance until the response handshake; response held while rsp_ready_i low.
// Ports: ref_clk_i clock, rstn_glob_i async active-low reset, bus = pll_cfg_initiator_if.master
//        (cmd valid/ready in, rsp valid/ready out, cfg_req/ack/add/data/wrn/r_data, cfg_lock_i in, lock_* out).
// Optional: define PLL_CFG_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES cycles without ack (rsp_err_o = 1).
module pll_cfg_initiator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LOSS_CNT_W     = 8
) (
  input logic                 ref_clk_i,
  input logic                 rstn_glob_i,
  pll_cfg_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state_q, state_d;
  logic   cmd_ready_q, cfg_req_q, rsp_valid_q;
  logic   cmd_ready_d, cfg_req_d, rsp_valid_d;
  logic [1:0]  cfg_add_q;
  logic [31:0] cfg_data_q, rsp_data_q;
  logic        cfg_wrn_q;
  logic        timeout;
  logic        req_done;

  // A request finishes on ack or on the (optional) timeout; ack has priority.
  assign req_done = (state_q == REQ) && (bus.cfg_ack_i || timeout);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid_i) state_d = REQ;
      REQ:     if (bus.cfg_ack_i || timeout) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of the next state's decode.
    cmd_ready_d = (state_d == IDLE);
    cfg_req_d   = (state_d == REQ);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cfg_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cfg_req_q   <= cfg_req_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      cfg_add_q  <= '0;
      cfg_data_q <= '0;
      cfg_wrn_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if ((state_q == IDLE) && bus.cmd_valid_i) begin
        cfg_add_q  <= bus.cmd_add_i;
        cfg_data_q <= bus.cmd_data_i;
        cfg_wrn_q  <= bus.cmd_wrn_i;
      end
      // Writes and timeouts return zero data.
      if (req_done)
        rsp_data_q <= (bus.cfg_ack_i && !cfg_wrn_q) ? bus.cfg_r_data_i : 32'd0;
    end
  end

`ifdef PLL_CFG_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;
  logic        rsp_err_q;

  assign timeout = (state_q == REQ) && (to_cnt_q == TO_LAST);

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      to_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.cmd_valid_i)
        to_cnt_q <= '0;
      else if ((state_q == REQ) && !bus.cfg_ack_i)
        to_cnt_q <= to_cnt_q + 16'd1;
      if (req_done)
        rsp_err_q <= !bus.cfg_ack_i;
    end
  end

  assign bus.rsp_err_o = rsp_err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |16'(TIMEOUT_CYCLES);
  assign timeout            = 1'b0;
  assign bus.rsp_err_o      = 1'b0;
`endif

  // Lock monitor: 2-FF synchroniser, then falling-edge detect on the synchronised flag.
  logic                  lock_s1_q, lock_q, lock_prev_q, irq_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic                  lock_fall;

  assign lock_fall = lock_prev_q && !lock_q;

  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      lock_s1_q   <= 1'b0;
      lock_q      <= 1'b0;
      lock_prev_q <= 1'b0;
      irq_q       <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      lock_s1_q   <= bus.cfg_lock_i;
      lock_q      <= lock_s1_q;
      lock_prev_q <= lock_q;
      irq_q       <= lock_fall;
      if (lock_fall && !(&loss_cnt_q))
        loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign bus.cmd_ready_o     = cmd_ready_q;
  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_data_o      = rsp_data_q;
  assign bus.cfg_req_o       = cfg_req_q;
  assign bus.cfg_add_o       = cfg_add_q;
  assign bus.cfg_data_o      = cfg_data_q;
  assign bus.cfg_wrn_o       = cfg_wrn_q;
  assign bus.lock_o          = lock_q;
  assign bus.lock_loss_cnt_o = loss_cnt_q;
  assign bus.lock_loss_irq_o = irq_q;

endmodule

// File: tb/tb_pll_cfg_initiator.sv
// Testbench for pll_cfg_initiator: directed and randomized transactions against a behavioural
// model of request length, response content and lock-loss pulse/count timing.
module tb_pll_cfg_initiator;
  localparam int TO_CYC = 8;
  localparam int LW     = 2;
  localparam int LW_MAX = (1 << LW) - 1;

  logic ref_clk_i   = 1'b0;
  logic rstn_glob_i = 1'b0;
  always #5 ref_clk_i = ~ref_clk_i;

  pll_cfg_initiator_if #(.LOSS_CNT_W(LW)) bus ();

  pll_cfg_initiator #(.TIMEOUT_CYCLES(TO_CYC), .LOSS_CNT_W(LW)) dut (
    .ref_clk_i  (ref_clk_i),
    .rstn_glob_i(rstn_glob_i),
    .bus        (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Every rising edge of cfg_req_o must be preceded by at least two low cycles.
  int   gap      = 0;
  bit   seen_req = 0;
  logic prev_req = 1'b0;
  always @(negedge ref_clk_i) begin
    if (!rstn_glob_i) begin
      seen_req = 0;
      prev_req = 1'b0;
      gap      = 0;
    end else begin
      if (bus.cfg_req_o && !prev_req) begin
        if (seen_req) chk("req_gap", 32'(gap >= 2), 32'd1);
        seen_req = 1;
        gap      = 0;
      end else if (!bus.cfg_req_o) begin
        gap++;
      end
      prev_req = bus.cfg_req_o;
    end
  end

  // Called just after a negedge. ack_dly: ack rises once req has been seen ack_dly cycles;
  // hold: ack high throughout; bp: cycles of response backpressure.
  task automatic run_txn(input logic [1:0] add, input logic [31:0] dat, input logic wrn,
                         input int ack_dly, input bit hold, input int bp, input logic [31:0] rdat);
    int          req_cyc, exp_cyc;
    bit          exp_err, stable;
    logic [31:0] exp_rdat;
    bus.cfg_r_data_i = rdat;
    bus.cfg_ack_i    = hold;
    chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_add_i   = add;
    bus.cmd_data_i  = dat;
    bus.cmd_wrn_i   = wrn;
    @(negedge ref_clk_i);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_add_i   = 2'($urandom_range(0, 3));
    bus.cmd_data_i  = $urandom();
    bus.cmd_wrn_i   = ~wrn;
    chk("req_rise", 32'(bus.cfg_req_o), 32'd1);
    req_cyc = 0;
    stable  = 1;
    while (bus.cfg_req_o && req_cyc < 100) begin
      if (bus.cfg_add_o !== add || bus.cfg_data_o !== dat || bus.cfg_wrn_o !== wrn ||
          bus.cmd_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) stable = 0;
      req_cyc++;
      if (!hold) bus.cfg_ack_i = (req_cyc > ack_dly);
      @(negedge ref_clk_i);
    end
    if (!hold) bus.cfg_ack_i = 1'b0;
    exp_cyc = hold ? 1 : ack_dly + 1;
    exp_err = 0;
`ifdef PLL_CFG_TIMEOUT_EN
    if (exp_cyc > TO_CYC) begin
      exp_cyc = TO_CYC;
      exp_err = 1;
    end
`endif
    exp_rdat = (wrn || exp_err) ? 32'd0 : rdat;
    chk("req_cycles", 32'(req_cyc), 32'(exp_cyc));
    chk("cfg_stable", 32'(stable), 32'd1);
    chk("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    chk("rsp_data", bus.rsp_data_o, exp_rdat);
    chk("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
    bus.rsp_ready_i = 1'b0;
    stable = 1;
    for (int k = 0; k < bp; k++) begin
      bus.cfg_r_data_i = $urandom();
      @(negedge ref_clk_i);
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== exp_rdat || bus.rsp_err_o !== exp_err ||
          bus.cfg_req_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) stable = 0;
    end
    chk("rsp_backpressure", 32'(stable), 32'd1);
    bus.rsp_ready_i = 1'b1;
    @(negedge ref_clk_i);
    bus.rsp_ready_i = 1'b0;
    bus.cfg_ack_i   = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid_o), 32'd0);
    chk("cmd_ready_back", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  task automatic reset_in_req();
    bit ok;
    bus.cfg_ack_i   = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_add_i   = 2'd1;
    bus.cmd_data_i  = 32'h5A5A_0001;
    bus.cmd_wrn_i   = 1'b1;
    @(negedge ref_clk_i);
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge ref_clk_i);
    chk("rst_pre_req", 32'(bus.cfg_req_o), 32'd1);
    @(posedge ref_clk_i);
    #2 rstn_glob_i = 1'b0;
    #1;
    chk("rst_req_async", 32'(bus.cfg_req_o), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    @(negedge ref_clk_i);
    rstn_glob_i = 1'b1;
    ok = 1;
    repeat (4) begin
      @(negedge ref_clk_i);
      if (bus.rsp_valid_o !== 1'b0 || bus.cfg_req_o !== 1'b0) ok = 0;
    end
    chk("rst_no_rsp", 32'(ok), 32'd1);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  logic lk_seq[$];

  function automatic bit hv(input int i);
    return (i < 0) ? 1'b0 : lk_seq[i];
  endfunction

  task automatic push_toggles(input int n);
    int d;
    for (int k = 0; k < n; k++) begin
      d = $urandom_range(1, 4);
      repeat (d) lk_seq.push_back(1'b1);
      d = $urandom_range(1, 4);
      repeat (d) lk_seq.push_back(1'b0);
    end
    repeat (8) lk_seq.push_back(1'b0);
  endtask

  // Value driven at negedge j is seen on lock_o at negedge j+2; a fall between
  // drives t-1 and t shows as an irq pulse at negedge t+3.
  task automatic lock_phase();
    int pulses, falls, mark1, cnt_exp;
    lk_seq.delete();
    repeat (4) lk_seq.push_back(1'b0);
    push_toggles(3);
    mark1 = lk_seq.size();
    push_toggles(2);
    pulses = 0;
    for (int j = 0; j < lk_seq.size(); j++) begin
      @(negedge ref_clk_i);
      falls = 0;
      for (int t = 1; t <= j - 3; t++) if (lk_seq[t-1] && !lk_seq[t]) falls++;
      cnt_exp = (falls > LW_MAX) ? LW_MAX : falls;
      chk("lock_o", 32'(bus.lock_o), 32'(hv(j - 2)));
      chk("lock_irq", 32'(bus.lock_loss_irq_o), 32'(hv(j - 4) && !hv(j - 3)));
      chk("loss_cnt", 32'(bus.lock_loss_cnt_o), 32'(cnt_exp));
      if (bus.lock_loss_irq_o) pulses++;
      if (j == mark1) begin
        chk("loss_cnt_after3", 32'(bus.lock_loss_cnt_o), 32'd3);
        chk("irq_pulses_3", 32'(pulses), 32'd3);
      end
      bus.cfg_lock_i = lk_seq[j];
    end
    chk("loss_cnt_sat", 32'(bus.lock_loss_cnt_o), 32'(LW_MAX));
    chk("irq_pulses_5", 32'(pulses), 32'd5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_add_i    = 2'd0;
    bus.cmd_data_i   = 32'd0;
    bus.cmd_wrn_i    = 1'b0;
    bus.rsp_ready_i  = 1'b0;
    bus.cfg_ack_i    = 1'b0;
    bus.cfg_r_data_i = 32'd0;
    bus.cfg_lock_i   = 1'b0;
    rstn_glob_i      = 1'b0;
    repeat (3) @(negedge ref_clk_i);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_cfg_req", 32'(bus.cfg_req_o), 32'd0);
    rstn_glob_i = 1'b1;
    @(negedge ref_clk_i);
    chk("init_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("init_cfg_req", 32'(bus.cfg_req_o), 32'd0);
    chk("init_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("init_rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("init_rsp_data", bus.rsp_data_o, 32'd0);
    chk("init_cfg_add", 32'(bus.cfg_add_o), 32'd0);
    chk("init_cfg_data", bus.cfg_data_o, 32'd0);
    chk("init_cfg_wrn", 32'(bus.cfg_wrn_o), 32'd0);
    chk("init_lock", 32'(bus.lock_o), 32'd0);
    chk("init_irq", 32'(bus.lock_loss_irq_o), 32'd0);
    chk("init_loss_cnt", 32'(bus.lock_loss_cnt_o), 32'd0);

    run_txn(2'd2, 32'h0000_00A5, 1'b1, 3, 1'b0, 0, $urandom());
    run_txn(2'd1, $urandom(), 1'b0, 0, 1'b1, 0, 32'h1234_5678);
    run_txn(2'd0, $urandom(), 1'b0, 0, 1'b1, 0, 32'h1234_5678);
    run_txn(2'd3, $urandom(), 1'b0, 2, 1'b0, 5, 32'hCAFE_0001);
    run_txn(2'd1, $urandom(), 1'b1, 30, 1'b0, 0, $urandom());
    run_txn(2'd2, $urandom(), 1'b0, TO_CYC - 1, 1'b0, 1, $urandom());
    run_txn(2'd0, $urandom(), 1'b0, 1, 1'b0, 0, $urandom());
    repeat (12) begin
      run_txn(2'($urandom_range(0, 3)), $urandom(), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom());
    end

    reset_in_req();
    lock_phase();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
